ne_decoder_hd_unloader: RTL



---
 rtl/ne_decoder_hd_unloader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ne_decoder_hd_unloader.sv
// Unloads decoded hard-decision bits from the LDPC core, one address at a time,
// and streams them out as HDWIDTH-bit valid/ready words (address-major, circulant-minor).
module ne_decoder_hd_unloader #(
  parameter int unsigned Kb           = 14,
  parameter int unsigned HDWIDTH      = 32,
  parameter int unsigned ADDRESSWIDTH = 5,
  parameter int unsigned UNLOAD_DEPTH = 16,
  parameter int unsigned LAST_VALID   = 31,
  parameter int unsigned RD_LAT       = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       decoder_ready,
  output logic                       unload_en,
  output logic [ADDRESSWIDTH-1:0]    unloadAddress,
  input  logic [Kb*HDWIDTH-1:0]      unload_HDout_vec_regout,
  output logic [HDWIDTH-1:0]         out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       unload_err
);

  localparam int unsigned VEC_W  = Kb * HDWIDTH;
  localparam int unsigned WORD_W = (Kb > 1) ? $clog2(Kb) : 1;
  localparam int unsigned LAT_W  = $clog2(RD_LAT) + 1;
  localparam logic [ADDRESSWIDTH-1:0] ADDR_LAST = ADDRESSWIDTH'(UNLOAD_DEPTH - 1);
  localparam logic [WORD_W-1:0]       W_LAST    = WORD_W'(Kb - 1);
  localparam logic [WORD_W-1:0]       W_PENULT  = WORD_W'(Kb - 2);
  localparam logic [LAT_W-1:0]        LAT_LAST  = LAT_W'(RD_LAT - 1);
  localparam logic [HDWIDTH-1:0]      LAST_MASK = HDWIDTH'((64'd1 << LAST_VALID) - 64'd1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_STREAM, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [ADDRESSWIDTH-1:0]   addr_d;
  logic [WORD_W-1:0]         w_q, w_d;
  logic [LAT_W-1:0]          lat_q, lat_d;
  logic [VEC_W-1:0]          buf_q, buf_d;
  logic                      armed_q, armed_d;
  logic                      err_d;
  logic [HDWIDTH-1:0]        out_data_d;
  logic                      out_last_d;
  logic                      last_addr;
  logic [HDWIDTH-1:0]        word_mask;

  // Words of the final address carry fewer than HDWIDTH meaningful bits.
  assign last_addr = (unloadAddress == ADDR_LAST);
  assign word_mask = last_addr ? LAST_MASK : '1;

  always_comb begin
    state_d    = state_q;
    addr_d     = unloadAddress;
    w_d        = w_q;
    lat_d      = lat_q;
    buf_d      = buf_q;
    armed_d    = armed_q;
    err_d      = unload_err;
    out_data_d = out_data;
    out_last_d = out_last;

    if (!decoder_ready) armed_d = 1'b1;
    if (busy && !decoder_ready) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (decoder_ready && armed_q) begin
          state_d = S_ISSUE;
          addr_d  = '0;
          armed_d = 1'b0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        lat_d   = '0;
      end
      S_WAIT: begin
        if (lat_q == LAT_LAST) begin
          state_d    = S_STREAM;
          buf_d      = unload_HDout_vec_regout;
          w_d        = '0;
          out_data_d = unload_HDout_vec_regout[HDWIDTH-1:0] & word_mask;
          out_last_d = (Kb == 1) && last_addr;
        end else begin
          lat_d = LAT_W'(lat_q + 1'b1);
        end
      end
      S_STREAM: begin
        if (out_ready) begin
          if (w_q == W_LAST) begin
            out_data_d = '0;
            out_last_d = 1'b0;
            if (last_addr) begin
              state_d = S_DONE;
            end else begin
              state_d = S_ISSUE;
              addr_d  = ADDRESSWIDTH'(unloadAddress + 1'b1);
            end
          end else begin
            w_d        = WORD_W'(w_q + 1'b1);
            buf_d      = buf_q >> HDWIDTH;
            out_data_d = buf_q[2*HDWIDTH-1:HDWIDTH] & word_mask;
            out_last_d = (w_q == W_PENULT) && last_addr;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered straight from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      unloadAddress <= '0;
      w_q           <= '0;
      lat_q         <= '0;
      buf_q         <= '0;
      armed_q       <= 1'b1;
      unload_err    <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      out_valid     <= 1'b0;
      unload_en     <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state_q       <= state_d;
      unloadAddress <= addr_d;
      w_q           <= w_d;
      lat_q         <= lat_d;
      buf_q         <= buf_d;
      armed_q       <= armed_d;
      unload_err    <= err_d;
      out_data      <= out_data_d;
      out_last      <= out_last_d;
      out_valid     <= (state_d == S_STREAM);
      unload_en     <= (state_d == S_ISSUE);
      busy          <= (state_d inside {S_ISSUE, S_WAIT, S_STREAM});
      frame_done    <= (state_d == S_DONE);
    end
  end

endmodule
